// File: rtl/mem_stage_hs_pkg.sv
// Shared types and decode helpers for the rv32i MEM stage.
package mem_stage_hs_pkg;

  typedef logic [1:0] mem_stage_state_t;

  localparam mem_stage_state_t ST_IDLE = 2'd0;
  localparam mem_stage_state_t ST_WAIT = 2'd1;
  localparam mem_stage_state_t ST_HOLD = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Unknown encodings fall back to a full word access.
  function automatic logic [1:0] access_size(input logic [2:0] f3, input logic is_load);
    if (f3 == F3_B || (is_load && f3 == F3_BU)) return SZ_B;
    if (f3 == F3_H || (is_load && f3 == F3_HU)) return SZ_H;
    return SZ_W;
  endfunction

endpackage

// File: rtl/mem_stage_hs_align.sv
// Combinational store lane steering, load extraction/extension and alignment check.
module mem_align
  import mem_stage_hs_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mbe,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  size;
  logic        sext;
  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    size   = access_size(funct3, is_load);
    sext   = (funct3 == F3_B) || (funct3 == F3_H);
    rshift = rdata >> {addr_lo, 3'b000};
    rbyte  = rshift[7:0];
    rhalf  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    misaligned = (is_load || is_store) &&
                 (((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00)));

    case (size)
      SZ_B: begin
        mbe        = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{sext & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        mbe        = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{sext & rhalf[15]}}, rhalf};
      end
      default: begin
        mbe        = 4'b1111;
        lane_wdata = wdata;
        load_data  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// rv32i MEM stage: data memory handshake FSM, MEM/WB register and stall accounting.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int TIMEOUT   = 0,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [2:0]           funct3_in,
  input  logic [31:0]          addr_in,
  input  logic [31:0]          wdata_in,
  input  logic                 stall_in,
  output logic                 stall_out,
  output logic [31:0]          data_addr,
  output logic [31:0]          data_wdata,
  output logic [3:0]           data_mbe,
  output logic                 data_read,
  output logic                 data_write,
  input  logic [31:0]          data_rdata,
  input  logic                 data_resp,
  output logic                 valid_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic [31:0]          rdata_out,
  output logic                 misaligned_out,
  output logic                 mem_err_out,
  output logic [PERF_W-1:0]    stall_cycles
);

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  mem_stage_state_t state, state_n;
  logic [31:0]      wait_cnt;

  // Request context captured at issue so WAIT/HOLD never depend on EX/MEM.
  logic [PAYLOAD_W-1:0] req_payload;
  logic [2:0]           req_f3;
  logic [31:0]          req_addr, req_wdata;
  logic                 req_rd, req_wr;

  logic [PAYLOAD_W-1:0] hold_payload;
  logic [31:0]          hold_rdata;
  logic                 hold_err;

  logic                 use_req;
  logic [2:0]           cur_f3;
  logic [31:0]          cur_addr, cur_wdata;
  logic                 cur_rd, cur_wr;

  logic [3:0]           al_mbe;
  logic [31:0]          al_wdata, al_rdata;
  logic                 al_mis;

  logic                 is_mem, issue, timeout_hit, done_mem, hold_capture;
  logic [31:0]          res_rdata;
  logic [PAYLOAD_W-1:0] res_payload;

  logic                 wb_valid, wb_mis, wb_err;
  logic [PAYLOAD_W-1:0] wb_payload;
  logic [31:0]          wb_rdata;

  assign use_req   = (state != ST_IDLE);
  assign cur_f3    = use_req ? req_f3    : funct3_in;
  assign cur_addr  = use_req ? req_addr  : addr_in;
  assign cur_wdata = use_req ? req_wdata : wdata_in;
  assign cur_rd    = use_req ? req_rd    : mem_read_in;
  assign cur_wr    = use_req ? req_wr    : mem_write_in;

  mem_align u_align (
    .funct3     (cur_f3),
    .addr_lo    (cur_addr[1:0]),
    .is_load    (cur_rd),
    .is_store   (cur_wr),
    .wdata      (cur_wdata),
    .rdata      (data_rdata),
    .mbe        (al_mbe),
    .lane_wdata (al_wdata),
    .load_data  (al_rdata),
    .misaligned (al_mis)
  );

  assign data_addr  = {cur_addr[31:2], 2'b00};
  assign data_wdata = al_wdata;
  assign data_mbe   = al_mbe;

  always_comb begin
    is_mem      = valid_in && (mem_read_in || mem_write_in);
    issue       = (state == ST_IDLE) && is_mem && !al_mis;
    timeout_hit = TO_EN && (state == ST_WAIT) && !data_resp && (wait_cnt == TO_LAST);
    done_mem    = (issue && data_resp) || ((state == ST_WAIT) && (data_resp || timeout_hit));
    res_rdata   = (cur_rd && !timeout_hit) ? al_rdata : 32'd0;
    res_payload = use_req ? req_payload : payload_in;
    data_read   = !rst && cur_rd && (issue || ((state == ST_WAIT) && !timeout_hit));
    data_write  = !rst && cur_wr && (issue || ((state == ST_WAIT) && !timeout_hit));
  end

  always_comb begin
    state_n      = state;
    stall_out    = stall_in;
    hold_capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue && !data_resp) begin
          state_n   = ST_WAIT;
          stall_out = 1'b1;
        end else if (issue && stall_in) begin
          state_n      = ST_HOLD;
          hold_capture = 1'b1;
        end
      end
      ST_WAIT: begin
        stall_out = 1'b1;
        if (done_mem) begin
          hold_capture = stall_in;
          state_n      = stall_in ? ST_HOLD : ST_IDLE;
          stall_out    = stall_in;
        end
      end
      ST_HOLD: begin
        if (!stall_in) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Next MEM/WB contents; only applied when downstream accepts.
  always_comb begin
    wb_valid   = 1'b0;
    wb_payload = payload_out;
    wb_rdata   = 32'd0;
    wb_mis     = 1'b0;
    wb_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!(issue && !data_resp)) begin
          wb_valid = valid_in;
          if (valid_in) wb_payload = payload_in;
          wb_rdata = done_mem ? res_rdata : 32'd0;
          wb_mis   = valid_in && al_mis;
        end
      end
      ST_WAIT: begin
        if (done_mem) begin
          wb_valid   = 1'b1;
          wb_payload = req_payload;
          wb_rdata   = res_rdata;
          wb_err     = timeout_hit;
        end
      end
      ST_HOLD: begin
        wb_valid   = 1'b1;
        wb_payload = hold_payload;
        wb_rdata   = hold_rdata;
        wb_err     = hold_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      req_payload    <= '0;
      req_f3         <= '0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_rd         <= 1'b0;
      req_wr         <= 1'b0;
      hold_payload   <= '0;
      hold_rdata     <= '0;
      hold_err       <= 1'b0;
      valid_out      <= 1'b0;
      payload_out    <= '0;
      rdata_out      <= '0;
      misaligned_out <= 1'b0;
      mem_err_out    <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 32'd1 : 32'd0;
      if (issue) begin
        req_payload <= payload_in;
        req_f3      <= funct3_in;
        req_addr    <= addr_in;
        req_wdata   <= wdata_in;
        req_rd      <= mem_read_in;
        req_wr      <= mem_write_in;
      end
      if (hold_capture) begin
        hold_payload <= res_payload;
        hold_rdata   <= res_rdata;
        hold_err     <= timeout_hit;
      end
      if (!stall_in) begin
        valid_out      <= wb_valid;
        payload_out    <= wb_payload;
        rdata_out      <= wb_rdata;
        misaligned_out <= wb_mis;
        mem_err_out    <= wb_err;
      end
      if (stall_out && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: alignment, wait states, timeout, hold and reset.
module tb_mem_stage_hs;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [127:0] payload_in;
  logic         mem_read_in, mem_write_in;
  logic [2:0]   funct3_in;
  logic [31:0]  addr_in, wdata_in;
  logic         stall_in;
  logic         stall_out;
  logic [31:0]  data_addr, data_wdata;
  logic [3:0]   data_mbe;
  logic         data_read, data_write;
  logic [31:0]  data_rdata;
  logic         data_resp;
  logic         valid_out;
  logic [127:0] payload_out;
  logic [31:0]  rdata_out;
  logic         misaligned_out, mem_err_out;
  logic [31:0]  stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [127:0] P2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] P1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] P3 = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] P4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [127:0] P5 = 128'h5555_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [127:0] P6 = 128'h6666_0000_0000_0000_0000_0000_0000_0006;
  localparam logic [127:0] P7 = 128'h7777_0000_0000_0000_0000_0000_0000_0007;
  localparam logic [127:0] P8 = 128'h8888_0000_0000_0000_0000_0000_0000_0008;

  mem_stage_hs #(.PAYLOAD_W(128), .TIMEOUT(4), .PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .payload_in     (payload_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .funct3_in      (funct3_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .stall_in       (stall_in),
    .stall_out      (stall_out),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_mbe       (data_mbe),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_rdata     (data_rdata),
    .data_resp      (data_resp),
    .valid_out      (valid_out),
    .payload_out    (payload_out),
    .rdata_out      (rdata_out),
    .misaligned_out (misaligned_out),
    .mem_err_out    (mem_err_out),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; payload_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    funct3_in = 3'b000; addr_in = '0; wdata_in = '0; stall_in = 1'b0;
    data_rdata = '0; data_resp = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    check("rst_valid",   128'(valid_out), 128'h0);
    check("rst_payload", payload_out, 128'h0);
    check("rst_rdata",   128'(rdata_out), 128'h0);
    check("rst_mis",     128'(misaligned_out), 128'h0);
    check("rst_err",     128'(mem_err_out), 128'h0);
    check("rst_stallc",  128'(stall_cycles), 128'h0);
    check("rst_read",    128'(data_read), 128'h0);

    // SB, zero-wait response
    payload_in = P1; valid_in = 1'b1; mem_write_in = 1'b1; funct3_in = 3'b000;
    addr_in = 32'h1003; wdata_in = 32'h0000_00A5; data_resp = 1'b1; #1;
    check("sb_mbe",   128'(data_mbe), 128'h8);
    check("sb_wdata", 128'(data_wdata), 128'hA5A5A5A5);
    check("sb_addr",  128'(data_addr), 128'h1000);
    check("sb_write", 128'(data_write), 128'h1);
    check("sb_read",  128'(data_read), 128'h0);
    check("sb_stall", 128'(stall_out), 128'h0);
    tick();
    valid_in = 1'b0; mem_write_in = 1'b0; data_resp = 1'b0; #1;
    check("sb_valid",   128'(valid_out), 128'h1);
    check("sb_payload", payload_out, P1);
    check("sb_stallc",  128'(stall_cycles), 128'h0);

    // LB with three wait cycles
    payload_in = P2; valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b000;
    addr_in = 32'h2001; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lb_stall", 128'(stall_out), 128'h1);
      check("lb_read",  128'(data_read), 128'h1);
      if (i > 0) check("lb_bubble", 128'(valid_out), 128'h0);
      tick();
    end
    data_rdata = 32'h0000_F000; data_resp = 1'b1; #1;
    check("lb_release", 128'(stall_out), 128'h0);
    tick();
    data_resp = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; #1;
    check("lb_valid",   128'(valid_out), 128'h1);
    check("lb_rdata",   128'(rdata_out), 128'hFFFFFFF0);
    check("lb_payload", payload_out, P2);
    check("lb_stallc",  128'(stall_cycles), 128'h3);

    // LHU then LH, same word
    payload_in = P3; valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b101;
    addr_in = 32'h2002; data_rdata = 32'h8001_0000; data_resp = 1'b1; #1;
    check("lhu_stall", 128'(stall_out), 128'h0);
    tick();
    check("lhu_rdata", 128'(rdata_out), 128'h00008001);
    payload_in = P4; funct3_in = 3'b001; #1;
    tick();
    check("lh_rdata",   128'(rdata_out), 128'hFFFF8001);
    check("lh_payload", payload_out, P4);

    // Misaligned LW
    payload_in = P5; funct3_in = 3'b010; addr_in = 32'h3002; data_resp = 1'b0; #1;
    check("mis_read",  128'(data_read), 128'h0);
    check("mis_stall", 128'(stall_out), 128'h0);
    tick();
    valid_in = 1'b0; mem_read_in = 1'b0; #1;
    check("mis_valid", 128'(valid_out), 128'h1);
    check("mis_flag",  128'(misaligned_out), 128'h1);
    check("mis_rdata", 128'(rdata_out), 128'h0);
    tick();
    check("mis_bubble", 128'(valid_out), 128'h0);
    check("mis_clear",  128'(misaligned_out), 128'h0);

    // LW timeout (TIMEOUT=4), then a stray response
    payload_in = P6; valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010;
    addr_in = 32'h4000; data_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_read", 128'(data_read), 128'h1);
      tick();
    end
    #1;
    check("to_drop",  128'(data_read), 128'h0);
    check("to_stall", 128'(stall_out), 128'h0);
    tick();
    valid_in = 1'b0; mem_read_in = 1'b0; data_resp = 1'b1; data_rdata = 32'h1234_5678; #1;
    check("to_err",     128'(mem_err_out), 128'h1);
    check("to_valid",   128'(valid_out), 128'h1);
    check("to_rdata",   128'(rdata_out), 128'h0);
    check("to_payload", payload_out, P6);
    check("to_late",    128'(data_read), 128'h0);
    check("to_stallc",  128'(stall_cycles), 128'h7);
    tick();
    data_resp = 1'b0; #1;
    check("to_bubble", 128'(valid_out), 128'h0);
    check("to_errclr", 128'(mem_err_out), 128'h0);
    check("to_idle",   128'(stall_out), 128'h0);

    // LW completes under downstream stall -> HOLD
    payload_in = P7; valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010;
    addr_in = 32'h5000; data_rdata = 32'hDEAD_BEEF; data_resp = 1'b1; stall_in = 1'b1; #1;
    check("hold_read0",  128'(data_read), 128'h1);
    check("hold_stall0", 128'(stall_out), 128'h1);
    tick();
    data_resp = 1'b0; data_rdata = 32'h0; #1;
    check("hold_read",    128'(data_read), 128'h0);
    check("hold_stall",   128'(stall_out), 128'h1);
    check("hold_payload", payload_out, P6);
    check("hold_valid",   128'(valid_out), 128'h0);
    tick();
    check("hold_payload2", payload_out, P6);
    stall_in = 1'b0; #1;
    check("hold_release", 128'(stall_out), 128'h0);
    tick();
    valid_in = 1'b0; mem_read_in = 1'b0; #1;
    check("hold_valid_o", 128'(valid_out), 128'h1);
    check("hold_rdata",   128'(rdata_out), 128'hDEADBEEF);
    check("hold_pl_out",  payload_out, P7);
    check("hold_stallc",  128'(stall_cycles), 128'h9);

    // Reset while waiting on memory
    payload_in = P8; valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 32'h6000; data_resp = 1'b0; #1;
    tick();
    check("rw_read",  128'(data_read), 128'h1);
    check("rw_stall", 128'(stall_out), 128'h1);
    rst = 1'b1; #1;
    check("rw_drop", 128'(data_read), 128'h0);
    tick();
    rst = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; data_resp = 1'b1; #1;
    check("rw_valid",   128'(valid_out), 128'h0);
    check("rw_payload", payload_out, 128'h0);
    check("rw_rdata",   128'(rdata_out), 128'h0);
    check("rw_stallc",  128'(stall_cycles), 128'h0);
    check("rw_err",     128'(mem_err_out), 128'h0);
    check("rw_mis",     128'(misaligned_out), 128'h0);
    check("rw_late",    128'(data_read), 128'h0);
    check("rw_stall0",  128'(stall_out), 128'h0);
    tick();
    data_resp = 1'b0; #1;
    check("rw_after", 128'(valid_out), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised MEM pipeline stage for the rv32i pipeline, between EX/MEM and MEM/WB.
- Performs load/store alignment and byte-enable generation, load sign/zero extension, and misalignment detection.
- Uses a request/response handshake with a multi-cycle data memory; stalls upstream until the response arrives.
- Carries an opaque payload (control word, PC, instruction, ALU result) through a posedge MEM/WB register with valid/stall flow control.

Parameters:
- PAYLOAD_W, 128, width of opaque pass-through bundle.
- TIMEOUT, 0, cycles to wait for data_resp before flagging mem_err_out; 0 disables.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  EX/MEM holds a valid instruction
- payload_in  in  PAYLOAD_W  pass-through bundle
- mem_read_in  in  1  instruction is a load
- mem_write_in  in  1  instruction is a store
- funct3_in  in  3  rv32i load/store funct3
- addr_in  in  32  effective address (ALU result)
- wdata_in  in  32  rs2 value
- stall_in  in  1  downstream (WB/hazard) cannot accept
- stall_out  out  1  hold EX/MEM and earlier stages
- data_addr  out  32  word-aligned address, {addr_in[31:2],2'b00}
- data_wdata  out  32  lane-shifted store data
- data_mbe  out  4  byte enables
- data_read  out  1  read request
- data_write  out  1  write request
- data_rdata  in  32  read word
- data_resp  in  1  memory completion, one-cycle pulse
- valid_out  out  1  MEM/WB valid
- payload_out  out  PAYLOAD_W  registered payload
- rdata_out  out  32  extended load data, 0 for non-loads
- misaligned_out  out  1  access violated natural alignment
- mem_err_out  out  1  timeout occurred
- stall_cycles  out  PERF_W  saturating count of cycles with stall_out high

Behaviour:
- Reset values (synchronous, rst high at posedge):
  - FSM in IDLE.
  - valid_out, payload_out, rdata_out, misaligned_out, mem_err_out, stall_cycles, and the wait counter all 0.
- Combinational outputs:
  - data_read/data_write are 0 whenever the FSM is not in IDLE-issuing or WAIT.
- Alignment:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access issues no request, completes in 1 cycle and sets misaligned_out=1.
  - rdata_out=0 for a misaligned access.
- Store lanes:
  - SB: mbe = 4'b0001<<addr[1:0]; wdata = byte replicated to all lanes.
  - SH: mbe = 4'b0011<<{addr[1],1'b0}; wdata = halfword replicated.
  - SW: mbe = 4'b1111.
- Load extension:
  - LB/LBU pick the byte at addr[1:0]; LH/LHU pick the half at addr[1]; LW takes the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 behaves as LW/SW.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, valid mem op, aligned: assert data_read/write combinationally.
    - data_resp same cycle: complete (0-wait).
    - No data_resp: go to WAIT; stall_out=1.
  - WAIT: request and address held stable until data_resp; the wait counter increments each cycle.
    - data_resp: capture extended data, then complete.
    - TIMEOUT!=0 and counter==TIMEOUT-1: drop the request, complete with mem_err_out=1 and rdata_out=0.
  - Complete, stall_in=0: load the MEM/WB register, return to IDLE, stall_out=0 that cycle.
  - Complete, stall_in=1: go to HOLD with the result latched in an internal holding register; stall_out=1 and no new request.
  - HOLD: when stall_in falls, load the MEM/WB register from the holding register and return to IDLE.
- Non-memory op, valid_in=1:
  - Passes through in 1 cycle unless stall_in is high.
  - If stall_in is high, MEM/WB holds its value and stall_out=stall_in.
- valid_in=0 or stall_in with nothing pending:
  - valid_out goes 0 only when the register is loaded with a bubble.
  - MEM/WB is held whenever stall_in=1.
- data_resp outside WAIT or same-cycle IDLE: ignored.
- rst during WAIT: requests drop that cycle and the FSM returns to IDLE; a late data_resp is ignored.
- stall_cycles: saturates at all-ones, no wrap.

Decomposition:
- rv32i_types gets new entries:
  - mem_stage_state_e enum (IDLE/WAIT/HOLD).
  - funct3 aliases for load/store widths.
- One sub-module, mem_align: purely combinational store lane/mbe generation, load extraction/extension and misalignment check.
- The FSM, counters and registers stay in mem_stage_hs.

Test Plan:
- SB addr 0x1003, wdata 0x000000A5, resp same cycle -> data_mbe=4'b1000, data_wdata=0xA5A5A5A5, data_addr=0x1000, stall_out never high.
- LB addr 0x2001, rdata 0x0000F000, resp after 3 cycles -> stall_out high 3 cycles, rdata_out=0xFFFFFFF0, stall_cycles=3.
- LHU addr 0x2002, rdata 0x8001_0000 -> rdata_out=0x00008001; LH same -> 0xFFFF8001.
- LW addr 0x3002 -> no data_read, misaligned_out=1, valid_out=1 next cycle, rdata_out=0.
- TIMEOUT=4, LW without resp -> data_read dropped after 4 cycles, mem_err_out=1; a later data_resp pulse is ignored.
- LW completes while stall_in=1 for 2 cycles -> FSM in HOLD, payload_out unchanged; after stall_in falls, rdata_out equals the captured word. Then rst asserted in WAIT -> all outputs 0 next cycle.
